cov_count_ctrl: RTL and testbench

COV_COUNT_CTRL -- requirements
Module: cov_count_ctrl

---
 rtl/cov_count_ctrl.sv | 147 ++++++++++++++
 tb/tb_cov_count_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cov_count_ctrl.sv
// cov_count_ctrl
//   Functional-coverage hit counter with a run/stop/dump controller.
//   While in RUN, every asserted cover signal bumps its own saturating hit
//   counter once per cycle. In DUMP the counters are streamed out one beat
//   per signal index over a valid/ready handshake. The dump does not change
//   the counter contents.
//
// Parameters
//   N   number of tracked cover signals (2..256)
//   CW  width of each hit counter (2..32)
//
// Ports
//   clock      single clock, all state changes on its rising edge
//   reset      synchronous active-low reset
//   cov_in     [N]  cover signals, bit i feeds counter i
//   start      pulse: IDLE -> RUN
//   stop       pulse: RUN -> IDLE (the cover sample of that cycle still counts)
//   clear      pulse: zero all counters and sat_any (honoured in IDLE only)
//   dump_req   pulse: IDLE -> DUMP
//   out_valid  a dump beat is being presented
//   out_ready  consumer accepts the current beat
//   out_index  signal index of the current beat
//   out_count  counter value of the current beat
//   out_last   current beat carries index N-1
//   busy       high in RUN or DUMP
//   sat_any    sticky flag: some counter reached its maximum since clear/reset
module cov_count_ctrl #(
  parameter int N  = 16,
  parameter int CW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  cov_in,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          dump_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic [CW-1:0] out_count,
  output logic          out_last,
  output logic          busy,
  output logic          sat_any
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_NEAR = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt [N];
  logic [IW-1:0] idx;
  logic          beat_accept;
  logic          at_last;
  logic          sat_hit;

  // Handshake decode; out_valid comes straight from the state register so
  // out_ready never reaches it combinationally.
  assign at_last     = (idx == LAST_IDX);
  assign beat_accept = (state == DUMP) && out_ready;

  // Next-state logic. start wins over dump_req when both arrive in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)         state_next = RUN;
        else if (dump_req) state_next = DUMP;
      end
      RUN: begin
        if (stop) state_next = IDLE;
      end
      DUMP: begin
        if (beat_accept && at_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Dump index pointer: parked at 0 outside DUMP so every dump begins at
  // signal 0, and wraps back to 0 once the last beat is taken.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx <= '0;
    end else if (beat_accept) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end else if (state != DUMP) begin
      idx <= '0;
    end
  end

  // Detects a counter that will hit its maximum at this edge, which is the
  // moment sat_any has to rise.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cov_in[i] && (cnt[i] == CNT_NEAR)) sat_hit = 1'b1;
    end
  end

  // Hit counters and the sticky saturation flag. Counters move only in RUN
  // (including the stop cycle) or when cleared from IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      sat_any <= 1'b0;
    end else if ((state == IDLE) && clear) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      sat_any <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cov_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
      end
      if (sat_hit) sat_any <= 1'b1;
    end
  end

  // Beat outputs are forced to zero outside DUMP so IDLE shows a clean bus.
  always_comb begin
    out_valid = (state == DUMP);
    busy      = (state != IDLE);
    out_index = '0;
    out_count = '0;
    out_last  = 1'b0;
    if (state == DUMP) begin
      out_index = idx;
      out_count = cnt[idx];
      out_last  = at_last;
    end
  end

endmodule

// File: tb/tb_cov_count_ctrl.sv
// tb_cov_count_ctrl
//   Directed bench for cov_count_ctrl. The main instance (N=4, CW=8) is
//   driven from a table of {inputs, expected outputs} records, followed by
//   hand-written stall and reset-during-dump sequences. A second instance
//   (N=4, CW=2) exercises counter saturation and the sat_any flag.
module tb_cov_count_ctrl;

  logic       clock;
  logic       reset;

  // Main instance signals
  logic [3:0] cov_in;
  logic       start, stop, clear, dump_req, out_ready;
  logic       out_valid, out_last, busy, sat_any;
  logic [1:0] out_index;
  logic [7:0] out_count;

  // Narrow-counter instance signals
  logic [3:0] s_cov_in;
  logic       s_start, s_stop, s_clear, s_dump_req, s_out_ready;
  logic       s_out_valid, s_out_last, s_busy, s_sat_any;
  logic [1:0] s_out_index;
  logic [1:0] s_out_count;

  int checks;
  int errors;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic       dump;
    logic       rdy;
    logic [3:0] cov;
    logic       valid;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       last;
    logic       busy;
    logic       sat;
  } vec_t;

  vec_t vecs[$];

  cov_count_ctrl #(.N(4), .CW(8)) dut (
    .clock(clock), .reset(reset), .cov_in(cov_in), .start(start), .stop(stop),
    .clear(clear), .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_count(out_count), .out_last(out_last),
    .busy(busy), .sat_any(sat_any)
  );

  cov_count_ctrl #(.N(4), .CW(2)) dut_sat (
    .clock(clock), .reset(reset), .cov_in(s_cov_in), .start(s_start), .stop(s_stop),
    .clear(s_clear), .dump_req(s_dump_req), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_index(s_out_index), .out_count(s_out_count), .out_last(s_out_last),
    .busy(s_busy), .sat_any(s_sat_any)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(logic r, logic st, logic sp, logic cl, logic dr, logic rd,
                              logic [3:0] cv, logic v, logic [1:0] ix, logic [7:0] ct,
                              logic l, logic b, logic s);
    vec_t t;
    t.rst = r; t.start = st; t.stop = sp; t.clear = cl; t.dump = dr; t.rdy = rd;
    t.cov = cv; t.valid = v; t.idx = ix; t.cnt = ct; t.last = l; t.busy = b; t.sat = s;
    return t;
  endfunction

  function automatic logic [15:0] packExp(vec_t t);
    return {2'b00, t.valid, t.idx, t.cnt, t.last, t.busy, t.sat};
  endfunction

  function automatic logic [15:0] packMain();
    return {2'b00, out_valid, out_index, out_count, out_last, busy, sat_any};
  endfunction

  function automatic logic [15:0] packSat();
    return {8'h00, s_out_valid, s_out_index, s_out_count, s_out_last, s_busy, s_sat_any};
  endfunction

  // Drive one vector on the falling edge, then step past the rising edge.
  task automatic applyStimulus(input vec_t t);
    @(negedge clock);
    reset = t.rst; start = t.start; stop = t.stop; clear = t.clear;
    dump_req = t.dump; out_ready = t.rdy; cov_in = t.cov;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulusSat(input logic st, input logic sp, input logic cl,
                                  input logic dr, input logic rd, input logic [3:0] cv);
    @(negedge clock);
    s_start = st; s_stop = sp; s_clear = cl; s_dump_req = dr; s_out_ready = rd; s_cov_in = cv;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Packed expectation for the narrow instance: {valid, idx, cnt, last, busy, sat}
  function automatic logic [15:0] sx(logic v, logic [1:0] ix, logic [1:0] ct,
                                     logic l, logic b, logic s);
    return {8'h00, v, ix, ct, l, b, s};
  endfunction

  initial begin
    logic [7:0] exp_cnt [4];
    logic       pat [4];
    int         exp_idx;

    checks = 0; errors = 0;
    reset = 1'b1; start = 0; stop = 0; clear = 0; dump_req = 0; out_ready = 0; cov_in = '0;
    s_start = 0; s_stop = 0; s_clear = 0; s_dump_req = 0; s_out_ready = 0; s_cov_in = '0;

    // Basic run, stop, dump with one stall on beat 0
    vecs.push_back(mk(0,0,0,0,0,0,4'h0, 0,0,8'd0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,4'h5, 0,0,8'd0,0,1,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0,0,0,4'h5, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,4'h0, 0,0,8'd0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0,4'h0, 1,0,8'd5,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,4'h0, 1,0,8'd5,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,1,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,2,8'd5,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,3,8'd0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 0,0,8'd0,0,0,0));
    // stop in IDLE is ignored; start+dump_req together enters RUN only
    vecs.push_back(mk(1,0,1,0,0,0,4'h0, 0,0,8'd0,0,0,0));
    vecs.push_back(mk(1,1,0,0,1,0,4'h0, 0,0,8'd0,0,1,0));
    // clear/start/dump_req during RUN are ignored and counting continues
    vecs.push_back(mk(1,1,0,1,1,0,4'h1, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,4'h0, 0,0,8'd0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,1,4'h0, 1,0,8'd6,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,1,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,2,8'd5,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,3,8'd0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 0,0,8'd0,0,0,0));
    // clear+start at one edge, then stop sampled with all cover bits set
    vecs.push_back(mk(1,1,0,1,0,0,4'h0, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,4'hF, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,4'hF, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,4'hF, 0,0,8'd0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,1,4'h0, 1,0,8'd3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,1,8'd3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,2,8'd3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 1,3,8'd3,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,1,4'h0, 0,0,8'd0,0,0,0));
    // make the counts distinct: +3,+2,+1,+0 on top of 3,3,3,3
    vecs.push_back(mk(1,1,0,0,0,0,4'h0, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,4'h1, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,4'h3, 0,0,8'd0,0,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,4'h7, 0,0,8'd0,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), packMain(), packExp(vecs[i]));
    end

    // Stalled dump with ready pattern 1,0,0,1: each beat must hold until taken
    exp_cnt[0] = 8'd6; exp_cnt[1] = 8'd5; exp_cnt[2] = 8'd4; exp_cnt[3] = 8'd3;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    applyStimulus(mk(1,0,0,0,1,0,4'h0, 0,0,0,0,0,0));
    exp_idx = 0;
    for (int cyc = 0; cyc < 40 && exp_idx < 4; cyc++) begin
      checkOutput($sformatf("stall_beat_c%0d", cyc),
                  {3'b000, out_valid, out_index, out_count, out_last, busy},
                  {3'b000, 1'b1, exp_idx[1:0], exp_cnt[exp_idx], (exp_idx == 3), 1'b1});
      @(negedge clock);
      out_ready = pat[cyc % 4];
      @(posedge clock);
      #1;
      if (pat[cyc % 4]) exp_idx++;
    end
    checkOutput("stall_beats_total", 16'(exp_idx), 16'd4);
    checkOutput("stall_end_idle", {14'd0, out_valid, busy}, 16'd0);

    // Reset while beat 2 is on the bus abandons the dump
    applyStimulus(mk(1,0,0,0,1,0,4'h0, 0,0,0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,1,4'h0, 0,0,0,0,0,0));
    applyStimulus(mk(1,0,0,0,0,1,4'h0, 0,0,0,0,0,0));
    checkOutput("pre_reset_beat2", packMain(), {2'b00, 1'b1, 2'd2, 8'd4, 1'b0, 1'b1, 1'b0});
    applyStimulus(mk(0,0,0,0,0,1,4'h0, 0,0,0,0,0,0));
    checkOutput("mid_dump_reset", packMain(), 16'd0);
    applyStimulus(mk(1,0,0,0,1,1,4'h0, 0,0,0,0,0,0));
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("post_reset_beat%0d", b), packMain(),
                  {2'b00, 1'b1, 2'(b), 8'd0, (b == 3), 1'b1, 1'b0});
      applyStimulus(mk(1,0,0,0,0,1,4'h0, 0,0,0,0,0,0));
    end
    checkOutput("post_reset_idle", packMain(), 16'd0);
    applyStimulus(mk(1,0,0,0,0,0,4'h0, 0,0,0,0,0,0));

    // Narrow counters: saturation at 3 and sat_any timing, then clear
    applyStimulusSat(1,0,0,0,0,4'h0);
    checkOutput("sat_start", packSat(), sx(0,0,0,0,1,0));
    for (int c = 1; c <= 6; c++) begin
      applyStimulusSat(0,0,0,0,0,4'h1);
      checkOutput($sformatf("sat_run%0d", c), packSat(), sx(0,0,0,0,1,(c >= 3)));
    end
    applyStimulusSat(0,1,0,0,0,4'h0);
    checkOutput("sat_stop", packSat(), sx(0,0,0,0,0,1));
    applyStimulusSat(0,0,0,1,1,4'h0);
    checkOutput("sat_beat0", packSat(), sx(1,0,3,0,1,1));
    for (int b = 1; b < 4; b++) begin
      applyStimulusSat(0,0,0,0,1,4'h0);
      checkOutput($sformatf("sat_beat%0d", b), packSat(), sx(1,2'(b),0,(b == 3),1,1));
    end
    applyStimulusSat(0,0,0,0,1,4'h0);
    checkOutput("sat_dump_done", packSat(), sx(0,0,0,0,0,1));
    applyStimulusSat(0,0,1,0,0,4'h0);
    checkOutput("sat_clear", packSat(), sx(0,0,0,0,0,0));
    applyStimulusSat(0,0,0,1,1,4'h0);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("clr_beat%0d", b), packSat(), sx(1,2'(b),0,(b == 3),1,0));
      applyStimulusSat(0,0,0,0,1,4'h0);
    end
    checkOutput("clr_dump_done", packSat(), sx(0,0,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
